// File: rtl/nvdla_sdp_rd_arb_pkg.sv
// rtl/nvdla_sdp_rd_arb_pkg.sv - shared field offsets, order-entry type and width helpers for the SDP read arbiter
package nvdla_sdp_rd_arb_pkg;

    localparam int MAX_CH       = 8;
    localparam int CH_ID_W      = 3;
    localparam int ORD_SIZE_W   = 15;
    localparam int REQ_ADDR_LSB = 0;

    // One entry per outstanding request; size is the beat count minus one
    typedef struct packed {
        logic [CH_ID_W-1:0]    ch_id;
        logic [ORD_SIZE_W-1:0] size;
    } ord_entry_t;

    localparam int ORD_ENTRY_W = $bits(ord_entry_t);

    function automatic int req_size_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int req_pd_w(input int addr_w, input int size_w);
        return addr_w + size_w;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nvdla_sdp_rd_ord_fifo.sv
// rtl/nvdla_sdp_rd_ord_fifo.sv - flop-based synchronous FIFO tracking outstanding read requests
module nvdla_sdp_rd_ord_fifo
    import nvdla_sdp_rd_arb_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nvdla_sdp_rd_arb.sv
// rtl/nvdla_sdp_rd_arb.sv - SDP read-request round-robin arbiter with credit budget and in-order response routing
// Optional stall counters enabled by NVDLA_SDP_RD_ARB_PERF_EN.
module nvdla_sdp_rd_arb
    import nvdla_sdp_rd_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 64,
    parameter int SIZE_W    = 15,
    parameter int RSP_PD_W  = 257,
    parameter int CDT_DEPTH = 16,
    parameter int ORD_DEPTH = 32
) (
    input  logic                               nvdla_core_clk,
    input  logic                               nvdla_core_rst,
    input  logic [NUM_CH-1:0]                  ch_rd_req_valid,
    output logic [NUM_CH-1:0]                  ch_rd_req_ready,
    input  logic [NUM_CH*(ADDR_W+SIZE_W)-1:0]  ch_rd_req_pd,
    input  logic [NUM_CH-1:0]                  ch_rd_cdt_lat_fifo_pop,
    output logic [NUM_CH-1:0]                  ch_rd_rsp_valid,
    input  logic [NUM_CH-1:0]                  ch_rd_rsp_ready,
    output logic [RSP_PD_W-1:0]                ch_rd_rsp_pd,
    output logic                               mem_rd_req_valid,
    input  logic                               mem_rd_req_ready,
    output logic [ADDR_W+SIZE_W-1:0]           mem_rd_req_pd,
    input  logic                               mem_rd_rsp_valid,
    output logic                               mem_rd_rsp_ready,
    input  logic [RSP_PD_W-1:0]                mem_rd_rsp_pd
`ifdef NVDLA_SDP_RD_ARB_PERF_EN
    ,
    output logic [NUM_CH*32-1:0]               perf_stall_cnt
`endif
);

    localparam int PD_W     = req_pd_w(ADDR_W, SIZE_W);
    localparam int SIZE_LSB = req_size_lsb(ADDR_W);
    localparam int CDT_W    = $clog2(CDT_DEPTH + 1);
    localparam int PTR_W    = clog2_min1(NUM_CH);

    logic [CDT_W-1:0]      credit     [NUM_CH];
    logic [31:0]           credit_sum [NUM_CH];
    logic [SIZE_W-1:0]     req_size   [NUM_CH];
    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     grant;
    logic                  grant_any;
    logic [PTR_W-1:0]      grant_id;
    logic [PD_W-1:0]       grant_pd;
    logic [PTR_W-1:0]      rr_ptr;
    logic                  out_valid;
    logic [PD_W-1:0]       out_pd;
    logic                  stage_free;
    ord_entry_t            ord_push_entry;
    ord_entry_t            ord_head;
    logic                  ord_full;
    logic                  ord_empty;
    logic                  ord_pop;
    logic                  rsp_fire;
    logic [ORD_SIZE_W-1:0] beat_cnt;

    assign stage_free = !out_valid || mem_rd_req_ready;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_size[i] = ch_rd_req_pd[i*PD_W + SIZE_LSB +: SIZE_W];
            eligible[i] = !nvdla_core_rst && ch_rd_req_valid[i] && !ord_full && stage_free &&
                          (32'(credit[i]) >= 32'(req_size[i]) + 32'd1);
        end
    end

    // Search starts at the pointer so the channel after the last grant wins ties
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_id  = PTR_W'(idx);
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
        grant_pd = ch_rd_req_pd[int'(grant_id)*PD_W +: PD_W];
    end

    assign ch_rd_req_ready  = grant;
    assign mem_rd_req_valid = out_valid;
    assign mem_rd_req_pd    = out_pd;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_pd    <= '0;
        end else if (grant_any) begin
            rr_ptr    <= (int'(grant_id) == NUM_CH - 1) ? '0 : grant_id + 1'b1;
            out_valid <= 1'b1;
            out_pd    <= grant_pd;
        end else if (mem_rd_req_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Grant and latency-FIFO pop on one channel combine into a single net update
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            credit_sum[i] = 32'(credit[i])
                          - (grant[i] ? 32'(req_size[i]) + 32'd1 : 32'd0)
                          + (ch_rd_cdt_lat_fifo_pop[i] ? 32'd1 : 32'd0);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (nvdla_core_rst) begin
                credit[i] <= CDT_W'(CDT_DEPTH);
            end else begin
                credit[i] <= CDT_W'(credit_sum[i]);
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_rd_req_valid[i]) begin
                    assert (32'(req_size[i]) + 32'd1 <= 32'(CDT_DEPTH));
                end
                assert (credit_sum[i] <= 32'(CDT_DEPTH));
            end
        end
    end

    assign ord_push_entry.ch_id = CH_ID_W'(grant_id);
    assign ord_push_entry.size  = ORD_SIZE_W'(req_size[grant_id]);

    nvdla_sdp_rd_ord_fifo #(
        .DEPTH (ORD_DEPTH),
        .WIDTH (ORD_ENTRY_W)
    ) u_ord_fifo (
        .clk       (nvdla_core_clk),
        .rst       (nvdla_core_rst),
        .push      (grant_any),
        .push_data (ord_push_entry),
        .pop       (ord_pop),
        .head_data (ord_head),
        .full      (ord_full),
        .empty     (ord_empty)
    );

    always_comb begin
        ch_rd_rsp_valid  = '0;
        mem_rd_rsp_ready = 1'b0;
        if (!nvdla_core_rst && !ord_empty) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(ord_head.ch_id) == i) begin
                    ch_rd_rsp_valid[i] = mem_rd_rsp_valid;
                    mem_rd_rsp_ready   = ch_rd_rsp_ready[i];
                end
            end
        end
    end

    assign ch_rd_rsp_pd = mem_rd_rsp_pd;
    assign rsp_fire     = mem_rd_rsp_valid && mem_rd_rsp_ready;
    assign ord_pop      = rsp_fire && (beat_cnt == ord_head.size);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            beat_cnt <= '0;
        end else if (rsp_fire) begin
            beat_cnt <= ord_pop ? '0 : beat_cnt + 1'b1;
        end
    end

`ifdef NVDLA_SDP_RD_ARB_PERF_EN
    logic [31:0] stall_cnt [NUM_CH];

    always_ff @(posedge nvdla_core_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (nvdla_core_rst) begin
                stall_cnt[i] <= '0;
            end else if (ch_rd_req_valid[i] && !ch_rd_req_ready[i] && (stall_cnt[i] != '1)) begin
                stall_cnt[i] <= stall_cnt[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_perf
        assign perf_stall_cnt[g*32 +: 32] = stall_cnt[g];
    end
`endif

endmodule

// File: tb/tb_nvdla_sdp_rd_arb.sv
// tb/tb_nvdla_sdp_rd_arb.sv - scoreboard bench for the SDP read arbiter
module tb_nvdla_sdp_rd_arb;

    localparam int NUM_CH    = 4;
    localparam int ADDR_W    = 64;
    localparam int SIZE_W    = 15;
    localparam int RSP_PD_W  = 257;
    localparam int CDT_DEPTH = 16;
    localparam int ORD_DEPTH = 32;
    localparam int PD_W      = ADDR_W + SIZE_W;

    typedef struct {
        int                  ch;
        logic [RSP_PD_W-1:0] data;
    } rsp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_CH-1:0]         req_valid = '0;
    logic [NUM_CH-1:0]         ch_rd_req_ready;
    logic [NUM_CH*PD_W-1:0]    req_pd = '0;
    logic [NUM_CH-1:0]         cdt_pop = '0;
    logic [NUM_CH-1:0]         ch_rd_rsp_valid;
    logic [NUM_CH-1:0]         ch_rsp_ready = '1;
    logic [RSP_PD_W-1:0]       ch_rd_rsp_pd;
    logic                      mem_rd_req_valid;
    logic                      mem_req_ready = 1'b1;
    logic [PD_W-1:0]           mem_rd_req_pd;
    logic                      mem_rsp_valid = 1'b0;
    logic                      mem_rd_rsp_ready;
    logic [RSP_PD_W-1:0]       mem_rsp_pd = '0;
`ifdef NVDLA_SDP_RD_ARB_PERF_EN
    logic [NUM_CH*32-1:0]      perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [PD_W-1:0] exp_req [$];
    rsp_t            exp_rsp [$];

    nvdla_sdp_rd_arb #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .SIZE_W    (SIZE_W),
        .RSP_PD_W  (RSP_PD_W),
        .CDT_DEPTH (CDT_DEPTH),
        .ORD_DEPTH (ORD_DEPTH)
    ) dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rst         (rst),
        .ch_rd_req_valid        (req_valid),
        .ch_rd_req_ready        (ch_rd_req_ready),
        .ch_rd_req_pd           (req_pd),
        .ch_rd_cdt_lat_fifo_pop (cdt_pop),
        .ch_rd_rsp_valid        (ch_rd_rsp_valid),
        .ch_rd_rsp_ready        (ch_rsp_ready),
        .ch_rd_rsp_pd           (ch_rd_rsp_pd),
        .mem_rd_req_valid       (mem_rd_req_valid),
        .mem_rd_req_ready       (mem_req_ready),
        .mem_rd_req_pd          (mem_rd_req_pd),
        .mem_rd_rsp_valid       (mem_rsp_valid),
        .mem_rd_rsp_ready       (mem_rd_rsp_ready),
        .mem_rd_rsp_pd          (mem_rsp_pd)
`ifdef NVDLA_SDP_RD_ARB_PERF_EN
        ,
        .perf_stall_cnt         (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [PD_W-1:0] mk_pd(input int sz, input logic [ADDR_W-1:0] a);
        return {SIZE_W'(sz), a};
    endfunction

    // Scoreboard monitor: every handshake on either side consumes one expectation
    always @(negedge clk) begin
        if (mem_rd_req_valid && mem_req_ready) begin
            if (exp_req.size() == 0) begin
                chk("req_unexpected", 128'(mem_rd_req_pd), 128'(0));
                if (mem_rd_req_pd == '0) begin
                    errors++;
                    $display("FAIL req_unexpected actual=0 required=none");
                end
            end else begin
                chk("req_pd", 128'(mem_rd_req_pd), 128'(exp_req.pop_front()));
            end
        end
        if ($countones(ch_rd_rsp_valid) > 1) begin
            chk("rsp_onehot", 128'(ch_rd_rsp_valid), 128'(0));
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_rd_rsp_valid[c] && ch_rsp_ready[c]) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=ch%0d required=none", c);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    chk("rsp_ch", 128'(c), 128'(e.ch));
                    checks++;
                    if (ch_rd_rsp_pd !== e.data) begin
                        errors++;
                        $display("FAIL rsp_data actual=%0h required=%0h", ch_rd_rsp_pd, e.data);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req_valid     = '0;
        cdt_pop       = '0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        ch_rsp_ready  = '1;
        rst           = 1'b1;
        step(2);
        rst           = 1'b0;
    endtask

    // Holds valid until granted; returns at the start of the cycle after the grant
    task automatic issue(input int ch, input int sz, input logic [ADDR_W-1:0] a, input bit expect_req);
        int n;
        n = 0;
        req_pd[ch*PD_W +: PD_W] = mk_pd(sz, a);
        req_valid[ch] = 1'b1;
        if (expect_req) exp_req.push_back(mk_pd(sz, a));
        forever begin
            @(negedge clk);
            if (ch_rd_req_ready[ch]) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout actual=no_grant required=grant ch=%0d", ch);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic send_rsp(input int ch, input int beats, input int base);
        for (int b = 0; b < beats; b++) begin
            rsp_t e;
            int   n;
            n             = 0;
            mem_rsp_pd    = RSP_PD_W'(base + b);
            mem_rsp_valid = 1'b1;
            e.ch          = ch;
            e.data        = mem_rsp_pd;
            exp_rsp.push_back(e);
            forever begin
                @(negedge clk);
                if (mem_rd_rsp_ready) break;
                n++;
                if (n > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_timeout actual=not_ready required=ready ch=%0d", ch);
                    break;
                end
                @(posedge clk);
                #1;
            end
            @(posedge clk);
            #1;
        end
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        step(1);
        do_reset();
        @(negedge clk);
        chk("rst_req_valid", 128'(mem_rd_req_valid), 128'(0));
        chk("rst_req_pd", 128'(mem_rd_req_pd), 128'(0));
        chk("rst_ch_ready", 128'(ch_rd_req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(ch_rd_rsp_valid), 128'(0));
        chk("rst_rsp_ready", 128'(mem_rd_rsp_ready), 128'(0));
        for (int i = 0; i < NUM_CH; i++) chk("rst_credit", 128'(dut.credit[i]), 128'(16));
        step(1);

        // Single channel, 4-beat request
        issue(0, 3, 64'h1000, 1'b1);
        chk("t1_latency_valid", 128'(mem_rd_req_valid), 128'(1));
        chk("t1_credit", 128'(dut.credit[0]), 128'(12));
        step(1);
        send_rsp(0, 4, 'h500);
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("t1_fifo_empty_ready", 128'(mem_rd_rsp_ready), 128'(0));
        chk("t1_fifo_empty_valid", 128'(ch_rd_rsp_valid), 128'(0));
        step(1);
        mem_rsp_valid = 1'b0;

        // Round robin over four always-valid channels
        do_reset();
        for (int g = 0; g < 8; g++) exp_req.push_back(mk_pd(0, 64'h100 + 64'(g % 4)));
        for (int c = 0; c < NUM_CH; c++) req_pd[c*PD_W +: PD_W] = mk_pd(0, 64'h100 + 64'(c));
        req_valid = '1;
        step(8);
        req_valid = '0;
        step(2);
        chk("t2_req_drained", 128'(exp_req.size()), 128'(0));
        for (int i = 0; i < NUM_CH; i++) chk("t2_credit", 128'(dut.credit[i]), 128'(14));

        // Credit exhaustion on ch1
        do_reset();
        issue(1, 13, 64'h2000, 1'b1);
        chk("t3_credit_low", 128'(dut.credit[1]), 128'(2));
        req_pd[1*PD_W +: PD_W] = mk_pd(3, 64'h2100);
        exp_req.push_back(mk_pd(3, 64'h2100));
        req_valid[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_stall", 128'(ch_rd_req_ready), 128'(0));
            step(1);
        end
        cdt_pop[1] = 1'b1;
        @(negedge clk);
        chk("t3_pop1_stall", 128'(ch_rd_req_ready), 128'(0));
        step(1);
        @(negedge clk);
        chk("t3_pop2_stall", 128'(ch_rd_req_ready), 128'(0));
        step(1);
        cdt_pop[1] = 1'b0;
        @(negedge clk);
        chk("t3_grant_after_pops", 128'(ch_rd_req_ready), 128'(4'b0010));
        step(1);
        req_valid[1] = 1'b0;
        chk("t3_credit_zero", 128'(dut.credit[1]), 128'(0));

        // Pop and grant together on ch2
        do_reset();
        issue(2, 10, 64'h3000, 1'b1);
        chk("t4_credit_five", 128'(dut.credit[2]), 128'(5));
        req_pd[2*PD_W +: PD_W] = mk_pd(0, 64'h3100);
        exp_req.push_back(mk_pd(0, 64'h3100));
        req_valid[2] = 1'b1;
        cdt_pop[2]   = 1'b1;
        @(negedge clk);
        chk("t4_grant", 128'(ch_rd_req_ready), 128'(4'b0100));
        step(1);
        req_valid[2] = 1'b0;
        cdt_pop[2]   = 1'b0;
        chk("t4_credit_net", 128'(dut.credit[2]), 128'(5));

        // Order FIFO fills at 32 outstanding
        do_reset();
        for (int g = 0; g < ORD_DEPTH; g++) exp_req.push_back(mk_pd(0, 64'h200 + 64'(g % 4)));
        for (int c = 0; c < NUM_CH; c++) req_pd[c*PD_W +: PD_W] = mk_pd(0, 64'h200 + 64'(c));
        req_valid = '1;
        step(ORD_DEPTH);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_full_ready", 128'(ch_rd_req_ready), 128'(0));
            step(1);
        end
        exp_req.push_back(mk_pd(0, 64'h200));
        send_rsp(0, 1, 'h77);
        @(negedge clk);
        chk("t5_resume_grant", 128'(ch_rd_req_ready), 128'(4'b0001));
        step(1);
        req_valid = '0;
        step(2);
        chk("t5_req_drained", 128'(exp_req.size()), 128'(0));

        // Response routing with channel backpressure
        do_reset();
        issue(2, 1, 64'h4000, 1'b1);
        issue(1, 0, 64'h4100, 1'b1);
        step(1);
        ch_rsp_ready  = 4'b1011;
        mem_rsp_valid = 1'b1;
        mem_rsp_pd    = RSP_PD_W'(32'h99);
        @(negedge clk);
        chk("t8_bp_ready", 128'(mem_rd_rsp_ready), 128'(0));
        chk("t8_bp_route", 128'(ch_rd_rsp_valid), 128'(4'b0100));
        step(1);
        ch_rsp_ready  = '1;
        mem_rsp_valid = 1'b0;
        send_rsp(2, 2, 'h30);
        send_rsp(1, 1, 'h40);
        @(negedge clk);
        chk("t8_drained_ready", 128'(mem_rd_rsp_ready), 128'(0));
        step(1);

        // Memory backpressure holds the output stage
        do_reset();
        mem_req_ready = 1'b0;
        issue(3, 2, 64'h5000, 1'b1);
        req_pd[0 +: PD_W] = mk_pd(0, 64'h5100);
        exp_req.push_back(mk_pd(0, 64'h5100));
        req_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t6_hold_valid", 128'(mem_rd_req_valid), 128'(1));
            chk("t6_hold_pd", 128'(mem_rd_req_pd), 128'(mk_pd(2, 64'h5000)));
            chk("t6_hold_noready", 128'(ch_rd_req_ready), 128'(0));
            step(1);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("t6_accept_grant", 128'(ch_rd_req_ready), 128'(4'b0001));
        step(1);
        req_valid[0] = 1'b0;
        step(2);
        chk("t6_req_drained", 128'(exp_req.size()), 128'(0));

        // Reset in the middle of an outstanding request
        mem_req_ready = 1'b0;
        issue(1, 4, 64'h6000, 1'b0);
        req_pd[0 +: PD_W] = mk_pd(0, 64'h6100);
        req_valid[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("t7_rst_noready", 128'(ch_rd_req_ready), 128'(0));
        step(1);
        chk("t7_rst_valid", 128'(mem_rd_req_valid), 128'(0));
        chk("t7_rst_pd", 128'(mem_rd_req_pd), 128'(0));
        for (int i = 0; i < NUM_CH; i++) chk("t7_rst_credit", 128'(dut.credit[i]), 128'(16));
        rst           = 1'b0;
        req_valid     = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("t7_ord_cleared_ready", 128'(mem_rd_rsp_ready), 128'(0));
        chk("t7_ord_cleared_valid", 128'(ch_rd_rsp_valid), 128'(0));
        step(1);
        mem_rsp_valid = 1'b0;
        issue(0, 1, 64'h7000, 1'b1);
        step(1);
        send_rsp(0, 2, 'h88);
        step(2);

        chk("final_req_drained", 128'(exp_req.size()), 128'(0));
        chk("final_rsp_drained", 128'(exp_rsp.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
